// File: rtl/exn_ctrl_nest_pkg.sv
// Shared types for the nesting exception controller: exception codes, saved-context record, SR map.
// No logic; constants and typedefs only.
// Consumed by exn_ctrl_nest and its testbench.
package exn_ctrl_nest_pkg;

    // Exception cause codes reported on exn_type; IRQ line n reports EXN_IRQ_BASE + n.
    typedef enum logic [5:0] {
        EXN_RST      = 6'd0,
        EXN_IRQ      = 6'd1,
        EXN_SCALL    = 6'd2,
        EXN_UDF      = 6'd3,
        EXN_IRQ_BASE = 6'd16
    } exn_e;

    // Level field is wide enough to hold NIRQ (the idle level) for NIRQ up to 32.
    localparam int LVL_W = 6;

    // Controller-side part of a saved context; pc and einfo live in XLEN-wide side arrays.
    typedef struct packed {
        logic             ie;
        logic [1:0]       cr;
        logic [LVL_W-1:0] lvl;
    } ctx_t;

    // System-register addresses owned by this block.
    localparam logic [15:0] SR_IE    = 16'h0001;
    localparam logic [15:0] SR_IEN   = 16'h0002;
    localparam logic [15:0] SR_ESTAT = 16'h0003;
    localparam logic [15:0] SR_DEPTH = 16'h0004;
    localparam logic [15:0] SR_IPEND = 16'h0005;
    localparam logic [15:0] SR_SIE   = 16'h0010;
    localparam logic [15:0] SR_SCR   = 16'h0011;
    localparam logic [15:0] SR_ELR   = 16'h0012;
    localparam logic [15:0] SR_EINFO = 16'h0013;

endpackage

// File: rtl/exn_prio_enc.sv
// Lowest-set-bit finder: vld when any request is set, idx of the lowest set bit.
// Latency: purely combinational.
// Backpressure: none.
module exn_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/exn_ctrl_nest.sv
// Nesting exception/IRQ controller with a DEPTH-entry saved-context stack and SR access port.
// Latency: exn/eret combinational in the same cycle; state updates on the next posedge.
// Backpressure: none; IRQs are held off by ex_bubble, ie, level and a full stack. EXN_IRQ_LATCH_EN selects edge-latched IRQs.
module exn_ctrl_nest
    import exn_ctrl_nest_pkg::*;
#(
    parameter int NIRQ  = 8,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIRQ-1:0] irq,
    input  logic            ex_bubble,
    input  logic            mem_scall,
    input  logic            mem_udf,
    input  logic            mem_eret,
    input  logic            mem_mtsr,
    input  logic            mem_w_cr,
    input  logic [1:0]      mem_cmp_res,
    input  logic [XLEN-1:0] mem_op3,
    input  logic [XLEN-1:0] mem_alu_res,
    input  logic [XLEN-1:0] mem_nextpc,
    input  logic [1:0]      cmp_reg,
    input  logic [15:0]     sr_addr,
    output logic [XLEN-1:0] sr_rdata,
    output logic            exn,
    output logic [5:0]      exn_type,
    output logic            eret,
    output logic [XLEN-1:0] elr,
    output logic [1:0]      scr
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = $clog2(DEPTH);
    localparam int IW   = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    logic [SPW-1:0]   sp;
    logic             ie;
    logic [NIRQ-1:0]  ien;
    logic [LVL_W-1:0] cur_lvl;
    logic [1:0]       estat;
    ctx_t             stk_ctx   [DEPTH];
    logic [XLEN-1:0]  stk_pc    [DEPTH];
    logic [XLEN-1:0]  stk_einfo [DEPTH];

    logic [NIRQ-1:0]  irq_src;
    logic [NIRQ-1:0]  elig;
    logic             enc_vld;
    logic [IW-1:0]    enc_idx;
    logic             empty;
    logic             full;
    logic [IDXW-1:0]  top_idx;
    logic [IDXW-1:0]  push_idx;
    logic             true_ie;
    logic             sync_exn;
    logic             irq_take;
    logic [1:0]       cr_in;
    logic [XLEN-1:0]  einfo_in;
    logic [XLEN-1:0]  sr_rd;
    logic             sr_owned;

`ifdef EXN_IRQ_LATCH_EN
    logic [NIRQ-1:0]  pend;
    logic [NIRQ-1:0]  irq_q;
    logic [NIRQ-1:0]  pend_clr;
    assign irq_src = pend;
`else
    assign irq_src = irq;
`endif

    assign empty    = (sp == '0);
    assign full     = (sp == SPW'(DEPTH));
    assign top_idx  = IDXW'(sp - SPW'(1));
    assign push_idx = full ? IDXW'(DEPTH - 1) : IDXW'(sp);

    // An mtsr to SR_IE in this same cycle already counts for IRQ eligibility.
    assign true_ie  = (mem_mtsr && sr_addr == SR_IE) ? mem_op3[0] : ie;
    assign sync_exn = mem_scall | mem_udf;
    assign cr_in    = mem_w_cr ? mem_cmp_res : cmp_reg;
    assign einfo_in = sync_exn ? mem_alu_res : '0;

    // A line is a candidate only if enabled and strictly more urgent than the running level.
    for (genvar g = 0; g < NIRQ; g++) begin : g_elig
        assign elig[g] = irq_src[g] & ien[g] & (LVL_W'(g) < cur_lvl);
    end

    exn_prio_enc #(.N(NIRQ), .IW(IW)) u_prio (
        .req (elig),
        .vld (enc_vld),
        .idx (enc_idx)
    );

    assign irq_take = enc_vld & true_ie & ~full & ~ex_bubble & ~sync_exn & ~mem_eret;

    // Redirect decision: reset > scall > udf > eret > irq.
    always_comb begin
        exn      = 1'b0;
        eret     = 1'b0;
        exn_type = EXN_RST;
        if (!rst_n) begin
            exn      = 1'b1;
        end else if (mem_scall) begin
            exn      = 1'b1;
            exn_type = EXN_SCALL;
        end else if (mem_udf) begin
            exn      = 1'b1;
            exn_type = EXN_UDF;
        end else if (mem_eret) begin
            exn      = 1'b1;
            eret     = 1'b1;
        end else if (irq_take) begin
            exn      = 1'b1;
            exn_type = 6'(EXN_IRQ_BASE) + 6'(enc_idx);
        end
    end

    // System-register read mux; top-of-stack views read as zero when the stack is empty.
    always_comb begin
        sr_rd    = '0;
        sr_owned = 1'b1;
        case (sr_addr)
            SR_IE:    sr_rd = XLEN'(ie);
            SR_IEN:   sr_rd = XLEN'(ien);
            SR_ESTAT: sr_rd = XLEN'(estat);
            SR_DEPTH: sr_rd = XLEN'(sp);
            SR_IPEND: sr_rd = XLEN'(irq_src & ien);
            SR_SIE:   sr_rd = empty ? '0 : XLEN'(stk_ctx[top_idx].ie);
            SR_SCR:   sr_rd = empty ? '0 : XLEN'(stk_ctx[top_idx].cr);
            SR_ELR:   sr_rd = empty ? '0 : stk_pc[top_idx];
            SR_EINFO: sr_rd = empty ? '0 : stk_einfo[top_idx];
            default:  sr_owned = 1'b0;
        endcase
    end

    assign sr_rdata = sr_owned ? sr_rd : {XLEN{1'bz}};
    assign elr      = empty ? '0 : stk_pc[top_idx];
    assign scr      = empty ? '0 : stk_ctx[top_idx].cr;

    // Controller state and context stack: take/push, eret/pop, else SR writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp      <= '0;
            ie      <= 1'b0;
            ien     <= '0;
            cur_lvl <= LVL_W'(NIRQ);
            estat   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_ctx[i]   <= '0;
                stk_pc[i]    <= '0;
                stk_einfo[i] <= '0;
            end
        end else if (sync_exn || irq_take) begin
            stk_ctx[push_idx]   <= '{ie: ie, cr: cr_in, lvl: cur_lvl};
            stk_pc[push_idx]    <= mem_nextpc;
            stk_einfo[push_idx] <= einfo_in;
            ie                  <= 1'b0;
            // Only a sync exception can arrive with the stack full; it overwrites the top.
            if (full) begin
                estat[0] <= 1'b1;
            end else begin
                sp <= sp + SPW'(1);
            end
            if (irq_take) begin
                cur_lvl <= LVL_W'(enc_idx);
            end
        end else if (mem_eret) begin
            if (empty) begin
                estat[1] <= 1'b1;
            end else begin
                ie      <= stk_ctx[top_idx].ie;
                cur_lvl <= stk_ctx[top_idx].lvl;
                sp      <= sp - SPW'(1);
            end
        end else if (mem_mtsr) begin
            case (sr_addr)
                SR_IE:    ie    <= mem_op3[0];
                SR_IEN:   ien   <= mem_op3[NIRQ-1:0];
                SR_ESTAT: estat <= estat & ~mem_op3[1:0];
                SR_SIE:   if (!empty) stk_ctx[top_idx].ie <= mem_op3[0];
                SR_SCR:   if (!empty) stk_ctx[top_idx].cr <= mem_op3[1:0];
                SR_ELR:   if (!empty) stk_pc[top_idx]     <= mem_op3;
                SR_EINFO: if (!empty) stk_einfo[top_idx]  <= mem_op3;
                default:  ;
            endcase
        end
    end

`ifdef EXN_IRQ_LATCH_EN
    // Pending bits drop when their line is taken or when software W1Cs SR_IPEND.
    always_comb begin
        pend_clr = '0;
        if (irq_take) begin
            pend_clr[enc_idx] = 1'b1;
        end
        if (!exn && mem_mtsr && sr_addr == SR_IPEND) begin
            pend_clr = pend_clr | mem_op3[NIRQ-1:0];
        end
    end

    // Rising-edge capture of irq into the pending register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= '0;
            pend  <= '0;
        end else begin
            irq_q <= irq;
            pend  <= (pend | (irq & ~irq_q)) & ~pend_clr;
        end
    end
`endif

endmodule

// File: tb/tb_exn_ctrl_nest.sv
// Directed bench for exn_ctrl_nest with a queue-based context model checked every cycle.
// Latency: inputs driven 1ns after posedge, literal checks 3ns after, model compare on negedge.
// Backpressure: none; fixed-length stimulus plus a watchdog.
module tb_exn_ctrl_nest;
    import exn_ctrl_nest_pkg::*;

    localparam int NIRQ  = 8;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst_n;
    logic [NIRQ-1:0] irq;
    logic            ex_bubble, mem_scall, mem_udf, mem_eret, mem_mtsr, mem_w_cr;
    logic [1:0]      mem_cmp_res, cmp_reg;
    logic [XLEN-1:0] mem_op3, mem_alu_res, mem_nextpc;
    logic [15:0]     sr_addr;
    logic [XLEN-1:0] sr_rdata;
    logic            exn, eret;
    logic [5:0]      exn_type;
    logic [XLEN-1:0] elr;
    logic [1:0]      scr;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    exn_ctrl_nest #(.NIRQ(NIRQ), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .ex_bubble(ex_bubble),
        .mem_scall(mem_scall), .mem_udf(mem_udf), .mem_eret(mem_eret), .mem_mtsr(mem_mtsr),
        .mem_w_cr(mem_w_cr), .mem_cmp_res(mem_cmp_res), .mem_op3(mem_op3),
        .mem_alu_res(mem_alu_res), .mem_nextpc(mem_nextpc), .cmp_reg(cmp_reg),
        .sr_addr(sr_addr), .sr_rdata(sr_rdata), .exn(exn), .exn_type(exn_type),
        .eret(eret), .elr(elr), .scr(scr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          ie;
        bit [1:0]    cr;
        logic [31:0] pc;
        logic [31:0] einfo;
        int          lvl;
    } mctx_t;

    mctx_t       m_stk[$];
    bit          m_ie;
    bit [7:0]    m_ien;
    int          m_lvl;
    bit [1:0]    m_estat;
    bit [7:0]    m_pend;
    bit [7:0]    m_prev;

    function automatic bit [7:0] m_src();
`ifdef EXN_IRQ_LATCH_EN
        return m_pend;
`else
        return irq;
`endif
    endfunction

    // Decision for the current cycle: line is the IRQ taken, or -1.
    function automatic void m_out(output bit e, output bit [5:0] t, output bit r, output int line);
        bit tie;
        bit [7:0] src;
        e = 0; t = 0; r = 0; line = -1;
        if (!rst_n) begin
            e = 1;
        end else if (mem_scall) begin
            e = 1; t = 2;
        end else if (mem_udf) begin
            e = 1; t = 3;
        end else if (mem_eret) begin
            e = 1; r = 1;
        end else begin
            tie = (mem_mtsr && sr_addr == SR_IE) ? mem_op3[0] : m_ie;
            src = m_src();
            for (int i = 0; i < NIRQ; i++) begin
                if (line < 0 && src[i] && m_ien[i] && i < m_lvl) line = i;
            end
            if (line >= 0 && tie && m_stk.size() < DEPTH && !ex_bubble) begin
                e = 1; t = 6'(16 + line);
            end else begin
                line = -1;
            end
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        int n = m_stk.size();
        case (a)
            SR_IE:    return 32'(m_ie);
            SR_IEN:   return 32'(m_ien);
            SR_ESTAT: return 32'(m_estat);
            SR_DEPTH: return n;
            SR_IPEND: return 32'(m_src() & m_ien);
            SR_SIE:   return (n == 0) ? 0 : 32'(m_stk[n-1].ie);
            SR_SCR:   return (n == 0) ? 0 : 32'(m_stk[n-1].cr);
            SR_ELR:   return (n == 0) ? 0 : m_stk[n-1].pc;
            SR_EINFO: return (n == 0) ? 0 : m_stk[n-1].einfo;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        bit e, r;
        bit [5:0] t;
        int line, n;
        mctx_t c;
        bit [7:0] clr;
        m_out(e, t, r, line);
        n = m_stk.size();
        clr = 0;
        if (!rst_n) begin
            m_stk.delete();
            m_ie = 0; m_ien = 0; m_lvl = NIRQ; m_estat = 0; m_pend = 0; m_prev = 0;
        end else begin
            if (e && !r) begin
                c.ie    = m_ie;
                c.cr    = mem_w_cr ? mem_cmp_res : cmp_reg;
                c.pc    = mem_nextpc;
                c.einfo = (line < 0) ? mem_alu_res : 0;
                c.lvl   = m_lvl;
                if (n == DEPTH) begin
                    m_stk[n-1] = c;
                    m_estat[0] = 1;
                end else begin
                    m_stk.push_back(c);
                end
                m_ie = 0;
                if (line >= 0) begin
                    m_lvl = line;
                    clr[line] = 1;
                end
            end else if (r) begin
                if (n == 0) begin
                    m_estat[1] = 1;
                end else begin
                    c = m_stk.pop_back();
                    m_ie  = c.ie;
                    m_lvl = c.lvl;
                end
            end else if (mem_mtsr) begin
                case (sr_addr)
                    SR_IE:    m_ie = mem_op3[0];
                    SR_IEN:   m_ien = mem_op3[7:0];
                    SR_ESTAT: m_estat = m_estat & ~mem_op3[1:0];
                    SR_IPEND: clr = mem_op3[7:0];
                    SR_SIE:   if (n > 0) m_stk[n-1].ie = mem_op3[0];
                    SR_SCR:   if (n > 0) m_stk[n-1].cr = mem_op3[1:0];
                    SR_ELR:   if (n > 0) m_stk[n-1].pc = mem_op3;
                    SR_EINFO: if (n > 0) m_stk[n-1].einfo = mem_op3;
                    default:  ;
                endcase
            end
`ifdef EXN_IRQ_LATCH_EN
            m_pend = (m_pend | (irq & ~m_prev)) & ~clr;
            m_prev = irq;
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit e, r;
        bit [5:0] t;
        int line, n;
        if (chk_en) begin
            m_out(e, t, r, line);
            n = m_stk.size();
            chk("cyc_exn", 32'(exn), 32'(e));
            chk("cyc_eret", 32'(eret), 32'(r));
            if (e && !r) chk("cyc_exn_type", 32'(exn_type), 32'(t));
            chk("cyc_elr", elr, (n == 0) ? 0 : m_stk[n-1].pc);
            chk("cyc_scr", 32'(scr), (n == 0) ? 0 : 32'(m_stk[n-1].cr));
            chk("cyc_sr_rdata", sr_rdata, m_read(sr_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        mem_scall = 0; mem_udf = 0; mem_eret = 0; mem_mtsr = 0; mem_w_cr = 0; ex_bubble = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        mem_mtsr = 1; sr_addr = a; mem_op3 = d;
        step();
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        sr_addr = a;
        #1;
        chk(name, sr_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; irq = 0; ex_bubble = 0; mem_scall = 0; mem_udf = 0; mem_eret = 0;
        mem_mtsr = 0; mem_w_cr = 0; mem_cmp_res = 0; cmp_reg = 0; mem_op3 = 0;
        mem_alu_res = 0; mem_nextpc = 0; sr_addr = SR_DEPTH;

        // 1: reset
        @(posedge clk); #1; chk_en = 1;
        #2 chk("rst_exn", 32'(exn), 1); chk("rst_type", 32'(exn_type), 0);
        step();
        #2 chk("rst_exn2", 32'(exn), 1);
        rst_n = 1;
        #2 chk("post_rst_exn", 32'(exn), 0);
        rd("rst_depth", SR_DEPTH, 0);
        rd("rst_ie", SR_IE, 0);
        step();

        // 2: IRQ line 1 from 0x0A
        wr(SR_IEN, 32'hFF);
        wr(SR_IE, 1);
        irq = 8'h0A; mem_nextpc = 32'h100; cmp_reg = 2'b01;
        #2 chk("irq1_exn", 32'(exn), 1); chk("irq1_type", 32'(exn_type), 17);
        step(); irq = 0;
        rd("irq1_depth", SR_DEPTH, 1);
        rd("irq1_ie", SR_IE, 0);
        rd("irq1_elr", SR_ELR, 32'h100);
        chk("irq1_scr", 32'(scr), 1);

        // 3: nesting by level
        wr(SR_IE, 1);
        irq = 8'h20;
        #2 chk("lvl_block5", 32'(exn), 0);
        step();
        irq = 8'h21; mem_nextpc = 32'h140; mem_w_cr = 1; mem_cmp_res = 2'b10;
        #2 chk("irq0_type", 32'(exn_type), 16);
        step(); irq = 0;
        rd("irq0_depth", SR_DEPTH, 2);
        rd("irq0_scr", SR_SCR, 2);
        mem_eret = 1;
        #2 chk("eret_exn", 32'(exn), 1); chk("eret_flag", 32'(eret), 1);
        step();
        rd("eret_depth", SR_DEPTH, 1);
        rd("eret_ie", SR_IE, 1);
        irq = 8'h02;
        #2 chk("lvl_block1", 32'(exn), 0);
        step(); irq = 0;
        mem_eret = 1; step();
        irq = 8'h08; ex_bubble = 1;
        #2 chk("bubble_block", 32'(exn), 0);
        step(); irq = 0;

        // 4: stack overflow with syscalls
        for (int k = 0; k < 5; k++) begin
            mem_scall = 1; mem_alu_res = 32'hA0 + k; mem_nextpc = 32'h200 + 4 * k;
            if (k == 0) #2 chk("scall_type", 32'(exn_type), 2);
            step();
        end
        rd("ovf_depth", SR_DEPTH, 4);
        rd("ovf_estat", SR_ESTAT, 1);
        rd("ovf_einfo", SR_EINFO, 32'hA4);
        rd("ovf_elr", SR_ELR, 32'h210);
        wr(SR_IE, 1);
        irq = 8'h01;
        #2 chk("full_block", 32'(exn), 0);
        step(); irq = 0;
        mem_udf = 1; mem_scall = 1; mem_alu_res = 32'hB1;
        #2 chk("scall_over_udf", 32'(exn_type), 2);
        step();
        mem_udf = 1; mem_alu_res = 32'hB0;
        #2 chk("udf_type", 32'(exn_type), 3);
        step();
        rd("udf_einfo", SR_EINFO, 32'hB0);
        wr(SR_ESTAT, 1);
        rd("w1c_estat", SR_ESTAT, 0);
        wr(SR_ELR, 32'h300);
        rd("wr_elr", SR_ELR, 32'h300);
        chk("wr_elr_port", elr, 32'h300);
        repeat (4) begin mem_eret = 1; step(); end

        // 5: underflow; eret beats mtsr
        mem_eret = 1; mem_mtsr = 1; sr_addr = SR_IEN; mem_op3 = 0;
        #2 chk("udf_eret_exn", 32'(exn), 1); chk("udf_eret_flag", 32'(eret), 1);
        step();
        rd("unf_estat", SR_ESTAT, 2);
        rd("unf_ien_kept", SR_IEN, 32'hFF);
        rd("unf_depth", SR_DEPTH, 0);
        rd("empty_sie", SR_SIE, 0);
        wr(SR_ESTAT, 3);
        rd("clr_estat", SR_ESTAT, 0);

        // 6: pending visibility, then take via bypassed ie write
        wr(SR_IE, 0);
`ifdef EXN_IRQ_LATCH_EN
        irq = 8'h04; step(); irq = 0;
`else
        irq = 8'h04;
`endif
        rd("ipend_4", SR_IPEND, 4);
        step();
        mem_mtsr = 1; sr_addr = SR_IE; mem_op3 = 1;
        #2 chk("bypass_exn", 32'(exn), 1); chk("bypass_type", 32'(exn_type), 18);
        step(); irq = 0;
        rd("ipend_clr", SR_IPEND, 0);
        rd("take2_depth", SR_DEPTH, 1);
        rd("mtsr_dropped", SR_IE, 0);
`ifdef EXN_IRQ_LATCH_EN
        irq = 8'h40; step(); irq = 0;
        rd("ipend_40", SR_IPEND, 32'h40);
        step();
        wr(SR_IPEND, 32'h40);
        rd("ipend_w1c", SR_IPEND, 0);
`endif
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
